// File: rtl/surfturf_cmdq_pkg.sv
// Shared register map, version tag and byte-lane helper for the command queues.
// No logic of its own; imported by the queue core and its per-channel FIFO.
// Offsets are byte addresses within the decoded Wishbone window.
package surfturf_cmdq_pkg;

  localparam logic [5:0] STATUS_ADDR  = 6'h00;
  localparam logic [5:0] PARAMS_ADDR  = 6'h04;
  localparam logic [5:0] DATA_BASE    = 6'h20;
  localparam logic [7:0] CMDQ_VERSION = 8'h01;

  // Byte lanes that must all be selected for a data write to count as a push.
  function automatic logic [3:0] data_sel_mask(input int data_bits);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (i * 8 < data_bits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/surfturf_cmdq_fifo.sv
// Single command queue with first-word-fall-through registered stream output.
// Latency: push into an empty queue is visible on m_tvalid/m_tdata the next cycle.
// Backpressure: m_tready low holds m_tdata; a push while full is dropped and flagged.
module cmdq_fifo #(
  parameter int DATA_BITS  = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_BITS-1:0]  din,
  input  logic                  m_tready,
  output logic                  m_tvalid,
  output logic [DATA_BITS-1:0]  m_tdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_evt
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [DEPTH_LOG2:0]   remain, count_nxt;
  logic                  do_pop, do_push, bypass;
  logic [DATA_BITS-1:0]  head_nxt;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  // m_tvalid mirrors !empty, so a pop is simply a handshake on the output.
  assign do_pop       = m_tvalid & m_tready;
  assign do_push      = push & ~full;
  assign overflow_evt = push & full & ~flush;

  // Next pointers/count and the word that will sit on the output next cycle.
  always_comb begin
    rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(do_pop);
    wr_ptr_nxt = wr_ptr + DEPTH_LOG2'(do_push);
    remain     = count - (DEPTH_LOG2 + 1)'(do_pop);
    count_nxt  = remain + (DEPTH_LOG2 + 1)'(do_push);
    // Nothing left in RAM after the pop: the incoming word becomes the head directly.
    bypass     = do_push && (remain == '0);
    head_nxt   = bypass ? din : mem[rd_ptr_nxt];
  end

  // Pointer, occupancy and output register state; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      m_tvalid <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      m_tvalid <= (count_nxt != '0);
      if (count_nxt != '0) m_tdata <= head_nxt;
    end
  end

  // Queue storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/surfturf_cmdq_core.sv
// Wishbone-written bank of NCHAN command queues, each draining to an AXI4-Stream master.
// Latency: one-cycle Wishbone ack; pushed word appears on its stream the cycle after the write.
// Backpressure: per-channel cmd_tready; writes to a full queue are dropped and set sticky overflow.
module surfturf_cmdq_core
  import surfturf_cmdq_pkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int DATA_BITS  = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_BITS  = 6
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [ADDR_BITS-1:0]       wb_adr_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic [31:0]                wb_dat_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic [NCHAN*DATA_BITS-1:0] cmd_tdata,
  output logic [NCHAN-1:0]           cmd_tvalid,
  input  logic [NCHAN-1:0]           cmd_tready
);

  localparam logic [3:0] SEL_MASK = data_sel_mask(DATA_BITS);

  logic                ack;
  logic                wr_acc;
  logic                is_status, is_params;
  logic [NCHAN-1:0]    flush_q, ovf, ovf_evt, ovf_clr, push, full_v, empty_v;
  logic [DEPTH_LOG2:0] cnt [NCHAN];
  logic [31:0]         rdata;

  assign wb_ack_o  = ack & wb_cyc_i;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign wr_acc    = wb_cyc_i & wb_stb_i & ack & wb_we_i;
  assign is_status = (wb_adr_i == ADDR_BITS'(STATUS_ADDR));
  assign is_params = (wb_adr_i == ADDR_BITS'(PARAMS_ADDR));
  assign ovf_clr   = (wr_acc && is_status && wb_sel_i[2]) ? wb_dat_i[16 +: NCHAN] : '0;

  // Ack follows the strobe by one cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) ack <= 1'b0;
    else             ack <= wb_cyc_i & wb_stb_i;
  end

  // Flush requests become a one-cycle pulse into the queues; overflow is sticky, set beats clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      flush_q <= '0;
      ovf     <= '0;
    end else begin
      flush_q <= (wr_acc && is_status && wb_sel_i[0]) ? wb_dat_i[NCHAN-1:0] : '0;
      ovf     <= (ovf & ~ovf_clr) | ovf_evt;
    end
  end

  for (genvar n = 0; n < NCHAN; n++) begin : g_chan
    localparam logic [ADDR_BITS-1:0] CH_ADDR = ADDR_BITS'(DATA_BASE) + ADDR_BITS'(4 * n);

    // Partial byte-lane writes are acked but never push.
    assign push[n] = wr_acc && (wb_adr_i == CH_ADDR) && ((wb_sel_i & SEL_MASK) == SEL_MASK);

    cmdq_fifo #(
      .DATA_BITS  (DATA_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk          (wb_clk_i),
      .rst_n        (wb_rst_n_i),
      .flush        (flush_q[n]),
      .push         (push[n]),
      .din          (wb_dat_i[DATA_BITS-1:0]),
      .m_tready     (cmd_tready[n]),
      .m_tvalid     (cmd_tvalid[n]),
      .m_tdata      (cmd_tdata[n*DATA_BITS +: DATA_BITS]),
      .count        (cnt[n]),
      .full         (full_v[n]),
      .empty        (empty_v[n]),
      .overflow_evt (ovf_evt[n])
    );
  end

  // Combinational readback selected purely by address.
  always_comb begin
    rdata = '0;
    if (is_status) begin
      rdata[NCHAN-1:0]    = empty_v;
      rdata[8 +: NCHAN]   = full_v;
      rdata[16 +: NCHAN]  = ovf;
    end else if (is_params) begin
      rdata = {8'(NCHAN), 8'(DEPTH_LOG2), 8'(DATA_BITS), CMDQ_VERSION};
    end else begin
      for (int n = 0; n < NCHAN; n++) begin
        if (wb_adr_i == ADDR_BITS'(DATA_BASE) + ADDR_BITS'(4 * n)) rdata[DEPTH_LOG2:0] = cnt[n];
      end
    end
  end

  assign wb_dat_o = rdata;

endmodule
